// File: rtl/sram_like_arbiter_2x1.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sram_like_arbiter_2x1: merges the i-cache and data ports onto one        |
// | SRAM-like port and routes in-order responses back via an owner FIFO.     |
// | Optional build macro: ARB_ROUND_ROBIN_EN (round-robin on contention).    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sram_like_arbiter_2x1 #(
  parameter int MAX_OUT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok
);

  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] C_COUNT_MAX = CW'(MAX_OUT);
  localparam logic [PW-1:0] C_PTR_LAST  = PW'(MAX_OUT - 1);

  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } owner_e;

  logic [MAX_OUT-1:0] owner_q, owner_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               lock_q, lock_d;
  owner_e             lock_sel_q, lock_sel_d;
  owner_e             sel;
  owner_e             contested_sel;
  logic               full;
  logic               empty;
  logic               accept;
  logic               resp;
  logic               head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == C_PTR_LAST) ? '0 : p + PW'(1);
  endfunction

`ifdef ARB_ROUND_ROBIN_EN
  owner_e last_grant_q, last_grant_d;

  assign contested_sel = (last_grant_q == OWNER_INST) ? OWNER_DATA : OWNER_INST;
  assign last_grant_d  = accept ? sel : last_grant_q;

  always_ff @(posedge clk) begin
    if (rst) last_grant_q <= OWNER_INST;
    else     last_grant_q <= last_grant_d;
  end
`else
  assign contested_sel = OWNER_DATA;
`endif

  // A stalled request keeps its owner so mem_* stays stable until mem_addr_ok.
  always_comb begin
    sel = OWNER_INST;
    if (lock_q)                    sel = lock_sel_q;
    else if (inst_req && data_req) sel = contested_sel;
    else if (data_req)             sel = OWNER_DATA;
  end

  assign full   = (count_q == C_COUNT_MAX);
  assign empty  = (count_q == '0);
  assign accept = mem_req & mem_addr_ok;
  assign resp   = mem_data_ok & ~empty & ~rst;
  assign head   = owner_q[rd_ptr_q];

  assign mem_req   = (inst_req | data_req) & ~full & ~rst;
  assign mem_wr    = (sel == OWNER_DATA) ? data_wr    : inst_wr;
  assign mem_size  = (sel == OWNER_DATA) ? data_size  : inst_size;
  assign mem_addr  = (sel == OWNER_DATA) ? data_addr  : inst_addr;
  assign mem_wdata = (sel == OWNER_DATA) ? data_wdata : inst_wdata;

  assign inst_addr_ok = accept & (sel == OWNER_INST);
  assign data_addr_ok = accept & (sel == OWNER_DATA);
  assign inst_data_ok = resp & ~head;
  assign data_data_ok = resp & head;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  always_comb begin
    owner_d    = owner_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    lock_d     = lock_q;
    lock_sel_d = lock_sel_q;

    if (accept) begin
      owner_d[wr_ptr_q] = sel;
      wr_ptr_d          = ptr_inc(wr_ptr_q);
      lock_d            = 1'b0;
    end else if (mem_req) begin
      lock_d     = 1'b1;
      lock_sel_d = sel;
    end

    if (resp) rd_ptr_d = ptr_inc(rd_ptr_q);

    case ({accept, resp})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      lock_q     <= 1'b0;
      lock_sel_q <= OWNER_INST;
    end else begin
      owner_q    <= owner_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      lock_q     <= lock_d;
      lock_sel_q <= lock_sel_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_like_arbiter_2x1.sv
`default_nettype none
// Testbench for sram_like_arbiter_2x1: vector table for single-cycle behaviour,
// hand sequences for lock/full/reset, and a response-owner scoreboard.
module tb_sram_like_arbiter_2x1;

  localparam logic        I_WR    = 1'b0;
  localparam logic [1:0]  I_SIZE  = 2'd2;
  localparam logic [31:0] I_WDATA = 32'h1111_1111;
  localparam logic [31:0] I_ADDR0 = 32'h1000_0000;
  localparam logic        D_WR    = 1'b1;
  localparam logic [1:0]  D_SIZE  = 2'd1;
  localparam logic [31:0] D_WDATA = 32'h2222_2222;
  localparam logic [31:0] D_ADDR0 = 32'h2000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic [31:0] inst_rdata, data_rdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_addr_ok, mem_data_ok;

  int n_checks = 0;
  int n_errors = 0;
  logic sb[$];
  logic mon_owner;

  sram_like_arbiter_2x1 #(.MAX_OUT(2)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_idle();
    inst_req = 1'b0; data_req = 1'b0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
  endtask

  task automatic pulse_reset();
    set_idle();
    rst = 1'b1;
    sb.delete();
    step();
    rst = 1'b0;
  endtask

  task automatic respond(input logic [31:0] rdata);
    mem_data_ok = 1'b1;
    mem_rdata   = rdata;
    sample();
    step();
    mem_data_ok = 1'b0;
  endtask

  // Scoreboard: every response must reach the owner expected at issue time.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
    end else if (mem_data_ok) begin
      if (sb.size() == 0) begin
        check("empty_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
      end else begin
        mon_owner = sb.pop_front();
        check("resp_route", {30'd0, inst_data_ok, data_data_ok},
              mon_owner ? 32'd1 : 32'd2);
        check("resp_rdata", mon_owner ? data_rdata : inst_rdata, mem_rdata);
      end
    end else if (inst_data_ok || data_data_ok) begin
      check("spurious_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  typedef struct packed {
    logic inst_req;
    logic data_req;
    logic mem_addr_ok;
    logic mem_data_ok;
    logic e_mem_req;
    logic e_inst_aok;
    logic e_data_aok;
    logic e_sel_data;
  } vec_t;

  vec_t vecs[8];
  logic exp_grant[4];

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
`ifdef ARB_ROUND_ROBIN_EN
    exp_grant = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_grant = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif

    inst_wr = I_WR; inst_size = I_SIZE; inst_wdata = I_WDATA; inst_addr = I_ADDR0;
    data_wr = D_WR; data_size = D_SIZE; data_wdata = D_WDATA; data_addr = D_ADDR0;
    mem_rdata = 32'h0;

    // Everything held active during reset must not leak out.
    rst = 1'b1;
    inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
    sample();
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
    step();
    pulse_reset();

    for (int i = 0; i < 8; i++) begin
      inst_req    = vecs[i].inst_req;
      data_req    = vecs[i].data_req;
      mem_addr_ok = vecs[i].mem_addr_ok;
      mem_data_ok = vecs[i].mem_data_ok;
      mem_rdata   = 32'hABCD_0000 + 32'(i);
      sample();
      check($sformatf("vec%0d_mem_req", i), {31'd0, mem_req}, {31'd0, vecs[i].e_mem_req});
      check($sformatf("vec%0d_addr_ok", i), {30'd0, inst_addr_ok, data_addr_ok},
            {30'd0, vecs[i].e_inst_aok, vecs[i].e_data_aok});
      check($sformatf("vec%0d_rdata_bcast", i), {inst_rdata ^ data_rdata}, 32'd0);
      if (vecs[i].e_mem_req) begin
        check($sformatf("vec%0d_mem_addr", i), mem_addr,
              vecs[i].e_sel_data ? D_ADDR0 : I_ADDR0);
        check($sformatf("vec%0d_mem_ctl", i), {29'd0, mem_wr, mem_size},
              vecs[i].e_sel_data ? {29'd0, D_WR, D_SIZE} : {29'd0, I_WR, I_SIZE});
        check($sformatf("vec%0d_mem_wdata", i), mem_wdata,
              vecs[i].e_sel_data ? D_WDATA : I_WDATA);
      end
      step();
      pulse_reset();
    end

    // Single instruction read.
    inst_addr = 32'hBFC0_0000; inst_req = 1'b1; mem_addr_ok = 1'b1;
    sample();
    check("single_inst_aok", {31'd0, inst_addr_ok}, 32'd1);
    check("single_mem_addr", mem_addr, 32'hBFC0_0000);
    sb.push_back(1'b0);
    step();
    inst_req = 1'b0; mem_addr_ok = 1'b0;
    sample();
    check("single_inst_aok_pulse", {31'd0, inst_addr_ok}, 32'd0);
    step();
    step();
    respond(32'h3C08_BFAF);

    // Contention: data first, then inst.
    inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1;
    sample();
    check("contend_first", {30'd0, inst_addr_ok, data_addr_ok}, 32'd1);
    sb.push_back(1'b1);
    step();
    data_req = 1'b0;
    sample();
    check("contend_second", {30'd0, inst_addr_ok, data_addr_ok}, 32'd2);
    sb.push_back(1'b0);
    step();
    set_idle();
    respond(32'hD000_0001);
    respond(32'h1000_0002);

    // Lock: a stalled inst request keeps the port even after data arrives.
    inst_addr = 32'h1000_0040;
    data_addr = 32'h2000_0040;
    for (int c = 0; c < 4; c++) begin
      inst_req = 1'b1; data_req = (c >= 1); mem_addr_ok = 1'b0;
      sample();
      check($sformatf("lock_c%0d_mem_addr", c), mem_addr, 32'h1000_0040);
      check($sformatf("lock_c%0d_mem_req", c), {31'd0, mem_req}, 32'd1);
      step();
    end
    mem_addr_ok = 1'b1;
    sample();
    check("lock_release_aok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd2);
    sb.push_back(1'b0);
    step();
    inst_req = 1'b0;
    sample();
    check("lock_then_data_aok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd1);
    check("lock_then_data_addr", mem_addr, 32'h2000_0040);
    sb.push_back(1'b1);
    step();
    set_idle();
    respond(32'h1111_0003);
    respond(32'h2222_0004);

    // Full: third write waits until the cycle after a pop.
    data_req = 1'b1; mem_addr_ok = 1'b1;
    for (int c = 0; c < 2; c++) begin
      data_addr = 32'h2000_0100 + 32'(4 * c);
      sample();
      check($sformatf("full_acc%0d", c), {31'd0, data_addr_ok}, 32'd1);
      sb.push_back(1'b1);
      step();
    end
    data_addr = 32'h2000_0108;
    sample();
    check("full_blocked", {31'd0, mem_req}, 32'd0);
    step();
    mem_data_ok = 1'b1; mem_rdata = 32'hF000_0001;
    sample();
    check("full_pop_same_cycle", {31'd0, mem_req}, 32'd0);
    check("full_pop_same_aok", {31'd0, data_addr_ok}, 32'd0);
    step();
    mem_data_ok = 1'b0;
    sample();
    check("full_unblocked", {31'd0, mem_req}, 32'd1);
    check("full_third_aok", {31'd0, data_addr_ok}, 32'd1);
    sb.push_back(1'b1);
    step();
    set_idle();
    respond(32'hF000_0002);
    respond(32'hF000_0003);

    // Reset with two outstanding transactions.
    data_req = 1'b1; mem_addr_ok = 1'b1;
    sample(); step();
    sample(); step();
    pulse_reset();
    respond(32'hDEAD_BEEF);
    data_req = 1'b1; mem_addr_ok = 1'b1;
    for (int c = 0; c < 2; c++) begin
      sample();
      check($sformatf("post_rst_acc%0d", c), {31'd0, data_addr_ok}, 32'd1);
      sb.push_back(1'b1);
      step();
    end
    set_idle();
    respond(32'hCAFE_0001);
    respond(32'hCAFE_0002);

    // Grant order with both requesters held and responses flowing.
    pulse_reset();
    for (int k = 0; k < 4; k++) begin
      inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1;
      mem_data_ok = (k > 0); mem_rdata = 32'h0000_00F0 + 32'(k);
      sample();
      check($sformatf("grant%0d", k), {30'd0, inst_addr_ok, data_addr_ok},
            exp_grant[k] ? 32'd1 : 32'd2);
      sb.push_back(exp_grant[k]);
      step();
    end
    set_idle();
    respond(32'h0000_00F4);

    check("sb_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
